// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: operation codes and helpers.
// Benches and later blocks import these so mode names stay consistent.
package univ_reg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

  // True for operations that produce a new serial-out / carry bit.
  function automatic logic mode_updates_sout(input logic [MODE_W-1:0] m);
    return m != MODE_HOLD;
  endfunction

endpackage

// File: rtl/univ_reg_next.sv
// Combinational datapath of the universal register: computes next state and
// the bit shifted/rotated out (or carry/borrow) for every operation.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q_next,
  output logic              sout_next
);

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic             msb;
  logic             lsb;
  logic             carry;
  logic             borrow;

  assign msb = q[WIDTH-1];
  assign lsb = q[0];

  // A single-bit register degenerates: shifts take sin, rotates keep q.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_val = sin;
      assign shr_val = sin;
      assign rol_val = q;
      assign ror_val = q;
    end else begin : g_wn
      assign shl_val = {q[WIDTH-2:0], sin};
      assign shr_val = {sin, q[WIDTH-1:1]};
      assign rol_val = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_val = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  assign inc_val = q + WIDTH'(1);
  assign dec_val = q - WIDTH'(1);
  assign carry   = &q;
  assign borrow  = ~|q;

  always_comb begin
    q_next    = q;
    sout_next = 1'b0;
    case (mode)
      MODE_HOLD: begin
        q_next    = q;
        sout_next = 1'b0;
      end
      MODE_LOAD: begin
        q_next    = d;
        sout_next = 1'b0;
      end
      MODE_SHL: begin
        q_next    = shl_val;
        sout_next = msb;
      end
      MODE_SHR: begin
        q_next    = shr_val;
        sout_next = lsb;
      end
      MODE_ROL: begin
        q_next    = rol_val;
        sout_next = msb;
      end
      MODE_ROR: begin
        q_next    = ror_val;
        sout_next = lsb;
      end
      MODE_INC: begin
        q_next    = inc_val;
        sout_next = carry;
      end
      MODE_DEC: begin
        q_next    = dec_val;
        sout_next = borrow;
      end
      default: begin
        q_next    = q;
        sout_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Universal register: falling-edge WIDTH-bit state with hold/load/shift/rotate/
// inc/dec, plus registered complement, serial-out/carry and zero flag.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  nq,
  output logic              sout,
  output logic              zero
);

  logic [WIDTH-1:0] q_next;
  logic             sout_next;

  univ_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode      (mode),
    .q         (q),
    .d         (d),
    .sin       (sin),
    .q_next    (q_next),
    .sout_next (sout_next)
  );

  // nq and zero derive from q_next so they land on the same edge as q.
  always_ff @(negedge clk) begin
    if (rst) begin
      q    <= RESET_VAL;
      nq   <= ~RESET_VAL;
      sout <= 1'b0;
      zero <= (RESET_VAL == '0);
    end else if (en) begin
      q    <= q_next;
      nq   <= ~q_next;
      zero <= (q_next == '0);
      if (mode_updates_sout(mode)) begin
        sout <= sout_next;
      end
    end
  end

endmodule

// File: tb/tb_univ_reg.sv
// Directed self-checking bench for univ_reg (WIDTH=8, RESET_VAL=0), falling-edge
// clocked; inputs change and outputs are sampled 1 ns after each falling edge.
module tb_univ_reg;
  import univ_reg_pkg::*;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin;
  logic [W-1:0]  q;
  logic [W-1:0]  nq;
  logic          sout;
  logic          zero;

  int n_cmp;
  int n_bad;

  univ_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .nq   (nq),
    .sout (sout),
    .zero (zero)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full output check against a hand-computed q and sout.
  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic es);
    logic [W-1:0] enq;
    logic         ez;
    enq = ~eq;
    ez  = (eq == 8'h00);
    check({tag, ".q"},    64'(q),    64'(eq));
    check({tag, ".nq"},   64'(nq),   64'(enq));
    check({tag, ".sout"}, 64'(sout), 64'(es));
    check({tag, ".zero"}, 64'(zero), 64'(ez));
  endtask

  // Present inputs, then let exactly one falling edge take effect.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dv, input logic s);
    rst  = r;
    en   = e;
    mode = m;
    d    = dv;
    sin  = s;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sin = 1'b0;
    #2;

    // 1: reset overrides a pending load
    step(1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    check_all("reset", 8'h00, 1'b0);

    // 2: load then hold with en=0 while inputs toggle
    step(1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
    check_all("load_a5", 8'hA5, 1'b0);
    step(1'b0, 1'b0, MODE_INC, 8'h3C, 1'b1);
    check_all("en0_a", 8'hA5, 1'b0);
    step(1'b0, 1'b0, MODE_LOAD, 8'hC3, 1'b0);
    check_all("en0_b", 8'hA5, 1'b0);
    step(1'b0, 1'b0, MODE_SHL, 8'h00, 1'b1);
    check_all("en0_c", 8'hA5, 1'b0);

    // 3: shifts
    step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
    check_all("load_81", 8'h81, 1'b0);
    step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
    check_all("shl1", 8'h02, 1'b1);
    step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
    check_all("shl2", 8'h04, 1'b0);
    step(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b1);
    check_all("shr1", 8'h82, 1'b0);

    // 4: rotates
    step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
    step(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0);
    check_all("rol1", 8'h03, 1'b1);
    step(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0);
    check_all("ror1", 8'h81, 1'b1);
    step(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0);
    check_all("ror2", 8'hC0, 1'b1);

    // 5: increment wrap, decrement, then HOLD keeps sout
    step(1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0);
    check_all("load_fe", 8'hFE, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    check_all("inc_ff", 8'hFF, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    check_all("inc_wrap", 8'h00, 1'b1);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    check_all("dec_wrap", 8'hFF, 1'b1);
    step(1'b0, 1'b1, MODE_HOLD, 8'h12, 1'b0);
    check_all("hold_mode", 8'hFF, 1'b1);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    check_all("dec_fe", 8'hFE, 1'b0);

    // 6: count from zero, abort with reset
    step(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);
    check_all("reset2", 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
      check($sformatf("count%0d", i), 64'(q), 64'(i));
    end
    step(1'b1, 1'b1, MODE_INC, 8'h00, 1'b0);
    check_all("reset_abort", 8'h00, 1'b0);

    // d pulse between edges does not disturb outputs; only the edge value loads
    rst = 1'b0; en = 1'b1; mode = MODE_LOAD; d = 8'h33;
    #3 d = 8'hCC;
    #3 d = 8'h33;
    check("mid_pulse.q", 64'(q), 64'(8'h00));
    @(negedge clk);
    #1;
    check_all("load_after_pulse", 8'h33, 1'b0);

    // DEC borrow from zero after reset
    step(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);
    step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
    check_all("dec_borrow", 8'hFF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
